// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and helpers for the ALU operand-source selector.
// Revision : 1.0  - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Select width for a given source count; a 1-bit floor keeps ports legal.
    function automatic int sel_width(input int num_src);
        return (num_src > 2) ? $clog2(num_src) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : operand_skid_buf
// Brief    : Two-entry valid/ready skid buffer (head + skid register).
// Revision : 1.0  - initial release
// ============================================================================
module operand_skid_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_accept;
    logic             w_drain;

    // Ready depends on state alone so upstream never sees a combinational loop.
    assign o_ready  = (r_state != FULL);
    assign o_valid  = (r_state != EMPTY);
    assign o_data   = r_head;
    assign w_accept = i_valid & o_ready;
    assign w_drain  = o_valid & i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_head_nxt  = i_data;
                end
            end
            ONE: begin
                if (w_accept && !w_drain) begin
                    w_state_nxt = FULL;
                    w_skid_nxt  = i_data;
                end else if (w_accept && w_drain) begin
                    w_head_nxt  = i_data;
                end else if (w_drain) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_drain) begin
                    w_state_nxt = ONE;
                    w_head_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_src_select.sv
`default_nettype none
// ============================================================================
// Module   : alu_src_select
// Brief    : Registered operand-source selector with forwarding override,
//            sticky illegal-select flag and a 2-entry skid buffer.
// Revision : 1.0  - initial release
// ============================================================================
module alu_src_select
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NUM_SRC*WIDTH-1:0] Sources,
    input  logic [SEL_W-1:0]         Sel,
    input  logic                     FwdEn,
    input  logic [WIDTH-1:0]         FwdData,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [WIDTH-1:0]         SAMux,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic                     SelErr
);

    logic [WIDTH-1:0] w_src_word;
    logic [WIDTH-1:0] w_word;
    logic             w_sel_ok;
    logic             w_accept;
    logic             r_sel_err;

    assign w_sel_ok = (32'(Sel) < NUM_SRC);

    // Out-of-range selects match no source and fall through to zero.
    always_comb begin
        w_src_word = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (Sel == SEL_W'(k)) begin
                w_src_word = Sources[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_word   = FwdEn ? FwdData : w_src_word;
    assign w_accept = InValid & InReady;

    // Forwarding replaces the data but still reports a bad select.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end
    end

    assign SelErr = r_sel_err;

    operand_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk     (CLK),
        .rst     (Reset),
        .i_valid (InValid),
        .i_data  (w_word),
        .o_ready (InReady),
        .o_valid (OutValid),
        .o_data  (SAMux),
        .i_ready (OutReady)
    );

endmodule
`default_nettype wire
